gmii_stim_gen: RTL and testbench
================================

Name: gmii_stim_gen

Overview:
Parametrised, synthesisable GMII receive-side stimulus source. It replaces the static zero drive on phy_rxd/phy_rx_dv/phy_rx_er in the board-level bench. On command it emits complete Ethernet frames: preamble, SFD, patterned payload, CRC-32 FCS, then an inter-frame gap. It supports selectable payload patterns and error injection, so the bench can exercise the MAC receive path without an external PHY model.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (1..15)
MIN_IFG, 12, idle cycles after the last FCS byte (1..255)
LEN_WIDTH, 11, width of frame_len
MAX_LEN, 1514, upper clamp on payload length in bytes
FCS_ENABLE, 1, 1 = append 4-byte FCS; 0 = go straight from payload to IFG

Ports:
clk  in  1  single clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
start  in  1  request one frame; sampled only in IDLE
frame_len  in  LEN_WIDTH  payload byte count; latched on accepted start
mode  in  2  00 incrementing, 01 constant, 10 LFSR, 11 incrementing + error inject
seed  in  8  first payload byte / constant / LFSR seed; latched on accepted start
busy  out  1  high while a frame or its IFG is in progress
done  out  1  one-cycle pulse on the last IFG cycle
frame_count  out  16  frames completed; wraps 0xFFFF->0x0000
gmii_rxd  out  8  data byte to the DUT
gmii_rx_dv  out  1  data valid
gmii_rx_er  out  1  receive error

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE. gmii_rxd=0x00, gmii_rx_dv=0, gmii_rx_er=0, busy=0, done=0, frame_count=0. This applies mid-frame too; the frame is abandoned with no FCS and no IFG.
- FSM states: IDLE -> PREAMBLE -> SFD -> PAYLOAD -> FCS -> IFG -> IDLE. With FCS_ENABLE=0, PAYLOAD goes directly to IFG.
- Start acceptance:
  - start=1 in IDLE at edge N is accepted. It latches the clamped length L = max(1, min(frame_len, MAX_LEN)), plus mode and seed.
  - busy=1 from edge N.
  - The first preamble byte appears on gmii_rxd after edge N+1, giving 1-cycle latency.
  - start in any other state is ignored, not queued.
- PREAMBLE: PREAMBLE_LEN cycles, rxd=0x55, dv=1.
- SFD: 1 cycle, rxd=0xD5, dv=1.
- PAYLOAD: L cycles, dv=1; byte index i runs 0..L-1.
  - Incrementing: byte = (seed + i) mod 256; 0xFF wraps to 0x00.
  - Constant: byte = seed.
  - LFSR: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left. Byte 0 = seed, with seed 0x00 replaced by 0x01. The register advances once per byte.
  - Error inject (mode 11): data as incrementing. rx_er=1 for exactly the single cycle with i = L/2 (integer division). rxd carries the normal data byte on that cycle.
- FCS: 4 cycles, dv=1.
  - Value = complement of CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over the payload bytes only.
  - Emitted least-significant byte first.
  - CRC is updated combinationally per payload byte, so there is no bubble between payload and FCS.
- IFG: MIN_IFG cycles, dv=0, er=0, rxd=0x00.
  - done=1 on the final IFG cycle, and frame_count increments on the same edge.
  - The next edge returns to IDLE with busy=0.
  - A start sampled on the first IDLE cycle is accepted, so minimum frame-to-frame spacing is MIN_IFG+1 idle cycles.
- Outside PREAMBLE/SFD/PAYLOAD/FCS, dv=0 and rxd=0x00.
- All outputs are registered.

Test Plan:
- Incrementing, seed=0x31, frame_len=9, defaults -> 1-cycle latency; then 55x7, D5, 31 32 33 34 35 36 37 38 39, FCS 26 39 F4 CB (CRC 0xCBF43926); then 12 idle cycles; done pulses once; frame_count=1.
- Incrementing, seed=0xFE, frame_len=3 -> payload FE FF 00. Constant, seed=0xA5, frame_len=4 -> A5 A5 A5 A5.
- frame_len=0 -> exactly 1 payload byte. frame_len=2000 -> exactly 1514 payload bytes (dv high for 7+1+1514+4 = 1526 cycles).
- Mode 11, seed=0x00, frame_len=10 -> rx_er high only on the cycle carrying 0x05 (i=5); FCS still matches the incrementing data 00..09.
- start pulsed during PAYLOAD and again during IFG -> ignored, one frame only. start held high continuously -> frames separated by exactly 13 dv-low cycles; frame_count increments once per frame.
- reset_n=0 for one edge during PAYLOAD -> next cycle dv=0, rxd=0, busy=0, frame_count=0. A new start then produces a complete correct frame.

Source files
------------

// File: rtl/gmii_stim_gen.sv
// rtl/gmii_stim_gen.sv - GMII receive-side frame stimulus source with patterns, FCS and error injection
module gmii_stim_gen #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_IFG      = 12,
   parameter int LEN_WIDTH    = 11,
   parameter int MAX_LEN      = 1514,
   parameter bit FCS_ENABLE   = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic [1:0]           mode,
   input  logic [7:0]           seed,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          frame_count,
   output logic [7:0]           gmii_rxd,
   output logic                 gmii_rx_dv,
   output logic                 gmii_rx_er
);

   // One counter serves every state; it must hold both a payload index and the IFG count.
   localparam int CW = (LEN_WIDTH > 8) ? LEN_WIDTH : 8;
   localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_FCS, S_IFG
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [LEN_WIDTH-1:0] r_len;
   logic [1:0]           r_mode;
   logic [7:0]           r_seed;
   logic [7:0]           r_lfsr;
   logic [31:0]          r_crc;
   logic [7:0]           r_rxd;
   logic                 r_dv, r_er, r_busy, r_done;
   logic [15:0]          r_frame_count;

   logic [LEN_WIDTH-1:0] w_len_clamped;
   logic [7:0]           w_byte, w_rxd, w_fcs_byte;
   logic [31:0]          w_fcs;
   logic                 w_dv, w_er, w_accept, w_last_ifg;

   // Reflected CRC-32 update for one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int k = 0; k < 8; k++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Length clamp, payload byte selection and FCS byte lane selection.
   always_comb begin
      w_len_clamped = frame_len;
      if (frame_len == '0) begin
         w_len_clamped = LEN_WIDTH'(1);
      end else if (frame_len > MAX_L) begin
         w_len_clamped = MAX_L;
      end
      case (r_mode)
         2'b01:   w_byte = r_seed;
         2'b10:   w_byte = r_lfsr;
         default: w_byte = r_seed + r_cnt[7:0];
      endcase
      w_fcs = ~r_crc;
      case (r_cnt[1:0])
         2'd0:    w_fcs_byte = w_fcs[7:0];
         2'd1:    w_fcs_byte = w_fcs[15:8];
         2'd2:    w_fcs_byte = w_fcs[23:16];
         default: w_fcs_byte = w_fcs[31:24];
      endcase
   end

   // Next-state logic and the line values the current state wants on the next edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rxd       = 8'h00;
      w_dv        = 1'b0;
      w_er        = 1'b0;
      w_accept    = 1'b0;
      w_last_ifg  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_PREAMBLE;
               w_cnt_nxt   = '0;
            end
         end
         S_PREAMBLE: begin
            w_rxd = 8'h55;
            w_dv  = 1'b1;
            if (r_cnt == CW'(PREAMBLE_LEN - 1)) begin
               w_state_nxt = S_SFD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_SFD: begin
            w_rxd       = 8'hD5;
            w_dv        = 1'b1;
            w_state_nxt = S_PAYLOAD;
            w_cnt_nxt   = '0;
         end
         S_PAYLOAD: begin
            w_rxd = w_byte;
            w_dv  = 1'b1;
            w_er  = (r_mode == 2'b11) && (r_cnt == CW'(r_len >> 1));
            if (r_cnt == CW'(r_len) - 1'b1) begin
               w_state_nxt = FCS_ENABLE ? S_FCS : S_IFG;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_FCS: begin
            w_rxd = w_fcs_byte;
            w_dv  = 1'b1;
            if (r_cnt == CW'(3)) begin
               w_state_nxt = S_IFG;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_IFG: begin
            if (r_cnt == CW'(MIN_IFG - 1)) begin
               w_last_ifg  = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State and counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Registered line outputs, status and the completed-frame counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rxd         <= 8'h00;
         r_dv          <= 1'b0;
         r_er          <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_frame_count <= 16'h0000;
      end else begin
         r_rxd  <= w_rxd;
         r_dv   <= w_dv;
         r_er   <= w_er;
         r_busy <= (r_state != S_IDLE) || w_accept;
         r_done <= w_last_ifg;
         if (w_last_ifg) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   // Per-frame context: latched on accept, LFSR and CRC advance once per payload byte.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_len  <= w_len_clamped;
         r_mode <= mode;
         r_seed <= seed;
         r_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
         r_crc  <= 32'hFFFFFFFF;
      end else if (r_state == S_PAYLOAD) begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_crc  <= crc_byte(r_crc, w_byte);
      end
   end

   assign gmii_rxd    = r_rxd;
   assign gmii_rx_dv  = r_dv;
   assign gmii_rx_er  = r_er;
   assign busy        = r_busy;
   assign done        = r_done;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_gmii_stim_gen.sv
// tb/tb_gmii_stim_gen.sv - scoreboard bench for gmii_stim_gen with randomized frames
module tb_gmii_stim_gen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] frame_len = '0;
   logic [1:0]  mode = '0;
   logic [7:0]  seed = '0;
   logic        busy, done, gmii_rx_dv, gmii_rx_er;
   logic [15:0] frame_count;
   logic [7:0]  gmii_rxd;

   gmii_stim_gen dut (
      .clk(clk), .reset_n(reset_n), .start(start), .frame_len(frame_len),
      .mode(mode), .seed(seed), .busy(busy), .done(done), .frame_count(frame_count),
      .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       er;
   } beat_t;

   beat_t exp_q[$];
   int    gap_q[$];
   beat_t mon_b;
   int    tests = 0, fails = 0;
   int    exp_frames = 0, n_done = 0, done_target = 0;
   int    low_run = 0, dv_run = 0, last_dv_run = 0;
   logic  prev_dv = 1'b0, prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input logic [7:0] d, input logic er);
      beat_t b;
      b.d  = d;
      b.er = er;
      exp_q.push_back(b);
   endtask

   // Reference frame: preamble, SFD, pattern bytes, bit-serial CRC-32 FCS.
   task automatic push_frame(input int len, input logic [1:0] m, input logic [7:0] s);
      int          l;
      logic [7:0]  lf, d;
      logic [31:0] crc;
      logic        fb;
      l   = (len == 0) ? 1 : ((len > 1514) ? 1514 : len);
      lf  = (s == 8'h00) ? 8'h01 : s;
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < 7; i++) push_beat(8'h55, 1'b0);
      push_beat(8'hD5, 1'b0);
      for (int i = 0; i < l; i++) begin
         if (m == 2'b01) d = s;
         else if (m == 2'b10) d = lf;
         else d = 8'((int'(s) + i) % 256);
         push_beat(d, (m == 2'b11) && (i == l / 2));
         lf = {lf[6:0], ^(lf & 8'b1011_1000)};
         for (int k = 0; k < 8; k++) begin
            fb  = crc[0] ^ d[k];
            crc = crc >> 1;
            if (fb) crc = crc ^ 32'hEDB88320;
         end
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) push_beat(8'(crc >> (8 * k)), 1'b0);
      done_target++;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: busy stuck at %b, required 0", busy);
      end
   endtask

   task automatic send(input int len, input logic [1:0] m, input logic [7:0] s);
      wait_idle();
      frame_len = 11'(len);
      mode      = m;
      seed      = s;
      start     = 1'b1;
      push_frame(len, m, s);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Monitor: pops expected beats whenever dv is high, tracks run lengths and done.
   always @(posedge clk) begin
      #1;
      if (gmii_rx_dv) begin
         if (!prev_dv) begin
            gap_q.push_back(low_run);
            dv_run = 0;
         end
         dv_run++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: rxd=%h er=%b, no beat expected", gmii_rxd, gmii_rx_er);
         end else begin
            mon_b = exp_q.pop_front();
            chk("rxd", 32'(gmii_rxd), 32'(mon_b.d));
            chk("rx_er", 32'(gmii_rx_er), 32'(mon_b.er));
         end
      end else begin
         if (prev_dv) begin
            last_dv_run = dv_run;
            low_run = 0;
         end
         low_run++;
         chk("idle_rxd", 32'(gmii_rxd), 32'h0);
         chk("idle_er", 32'(gmii_rx_er), 32'h0);
      end
      if (done) begin
         n_done++;
         exp_frames++;
         chk("frame_count_at_done", 32'(frame_count), 32'(exp_frames));
         chk("done_after_ifg", 32'(low_run), 32'd12);
         chk("done_single_cycle", 32'(prev_done), 32'h0);
         chk("frame_drained_at_done", 32'(exp_q.size()), 32'h0);
      end
      prev_dv   = gmii_rx_dv;
      prev_done = done;
   end

   initial begin
      int nd, t;
      repeat (3) @(negedge clk);
      chk("reset_rxd", 32'(gmii_rxd), 32'h0);
      chk("reset_dv", 32'(gmii_rx_dv), 32'h0);
      chk("reset_er", 32'(gmii_rx_er), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_frame_count", 32'(frame_count), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Reference frame with literal expected bytes and latency checks.
      frame_len = 11'd9;
      mode      = 2'b00;
      seed      = 8'h31;
      start     = 1'b1;
      for (int i = 0; i < 7; i++) push_beat(8'h55, 1'b0);
      push_beat(8'hD5, 1'b0);
      for (int i = 0; i < 9; i++) push_beat(8'(8'h31 + i), 1'b0);
      push_beat(8'h26, 1'b0);
      push_beat(8'h39, 1'b0);
      push_beat(8'hF4, 1'b0);
      push_beat(8'hCB, 1'b0);
      done_target++;
      @(posedge clk);
      #1;
      chk("latency_busy", 32'(busy), 32'h1);
      chk("latency_dv_low", 32'(gmii_rx_dv), 32'h0);
      @(posedge clk);
      #1;
      chk("latency_first_dv", 32'(gmii_rx_dv), 32'h1);
      chk("latency_first_byte", 32'(gmii_rxd), 32'h55);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      chk("first_frame_count", 32'(frame_count), 32'h1);
      chk("first_done_count", 32'(n_done), 32'h1);

      // Pattern and length boundaries.
      send(3, 2'b00, 8'hFE);
      send(4, 2'b01, 8'hA5);
      send(0, 2'b00, 8'h77);
      wait_idle();
      chk("len0_dv_cycles", 32'(last_dv_run), 32'd13);
      send(2000, 2'b10, 8'h00);
      wait_idle();
      chk("len_clamp_dv_cycles", 32'(last_dv_run), 32'd1526);
      send(10, 2'b11, 8'h00);
      send(1, 2'b11, 8'h9C);

      // Start pulses during payload and during IFG are ignored.
      send(12, 2'b00, 8'h10);
      repeat (12) @(negedge clk);
      chk("ignored_start_in_payload", 32'(gmii_rx_dv), 32'h1);
      frame_len = 11'd5;
      mode      = 2'b01;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (gmii_rx_dv && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("ignored_start_in_ifg", 32'(busy), 32'h1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Start held high: back-to-back frames at minimum spacing.
      frame_len = 11'd5;
      mode      = 2'b00;
      seed      = 8'hC0;
      start     = 1'b1;
      push_frame(5, 2'b00, 8'hC0);
      nd = n_done;
      for (int k = 1; k <= 3; k++) begin
         t = 0;
         while (n_done < nd + k && t < 3000) begin
            @(negedge clk);
            t++;
         end
         if (t >= 3000) begin
            tests++;
            fails++;
            $display("FAIL held_start_done: done count %0d, required %0d", n_done, nd + k);
         end
         if (k < 3) push_frame(5, 2'b00, 8'hC0);
         else start = 1'b0;
      end
      chk("held_gap_entries", 32'(gap_q.size() >= 3), 32'h1);
      if (gap_q.size() >= 3) begin
         chk("held_gap_a", 32'(gap_q[gap_q.size() - 2]), 32'd13);
         chk("held_gap_b", 32'(gap_q[gap_q.size() - 1]), 32'd13);
      end
      wait_idle();
      repeat (20) @(negedge clk);
      chk("held_stop_busy", 32'(busy), 32'h0);

      // Reset in the middle of the payload abandons the frame.
      send(20, 2'b00, 8'h40);
      repeat (14) @(negedge clk);
      chk("pre_reset_dv", 32'(gmii_rx_dv), 32'h1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_dv", 32'(gmii_rx_dv), 32'h0);
      chk("midreset_rxd", 32'(gmii_rxd), 32'h0);
      chk("midreset_busy", 32'(busy), 32'h0);
      chk("midreset_frame_count", 32'(frame_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      exp_frames = 0;
      done_target--;
      send(8, 2'b10, 8'h5A);
      wait_idle();
      chk("post_reset_frame_count", 32'(frame_count), 32'h1);

      // Randomized frames.
      for (int r = 0; r < 15; r++) begin
         send(int'($urandom_range(0, 40)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end

      wait_idle();
      repeat (5) @(negedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
      chk("final_done_count", 32'(n_done), 32'(done_target));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
